// File: rtl/score_link_pkg.sv
// Shared definitions for the scoreboard serial link (transmitter and display-side receiver).
package score_link_pkg;

    // Field widths of the score word
    localparam int RUNS_W  = 8;
    localparam int WKTS_W  = 4;
    localparam int BALLS_W = 7;

    // Data bits carried between start bit and parity bit
    localparam int DATA_W     = RUNS_W + WKTS_W + BALLS_W;
    // start + data + parity + stop
    localparam int FRAME_BITS = DATA_W + 3;

    // Saturation limits applied at snapshot time
    localparam logic [WKTS_W-1:0]  MAX_WKTS  = 4'd10;
    localparam logic [BALLS_W-1:0] MAX_BALLS = 7'd120;

    // FSM state encodings
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // Clamp wickets to the saturation value
    function automatic logic [WKTS_W-1:0] sat_wkts(input logic [WKTS_W-1:0] w);
        return (w > MAX_WKTS) ? MAX_WKTS : w;
    endfunction

    // Clamp balls to the saturation value
    function automatic logic [BALLS_W-1:0] sat_balls(input logic [BALLS_W-1:0] b);
        return (b > MAX_BALLS) ? MAX_BALLS : b;
    endfunction

endpackage

// File: rtl/score_frame_tx_bit_timer.sv
// Bit-period divider: pulses o_bit_end on the last clk cycle of each serial bit.
// Held at zero while disabled so it never free-runs between frames.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    input  logic i_enable,
    output logic o_bit_end
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last    = (r_cnt == LAST);
    assign o_bit_end = i_enable & ~i_restart & w_last;

    // Count clk cycles within the current bit; wrap at the end of each bit period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_restart || !i_enable || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/score_frame_tx.sv
// Scoreboard link transmitter: snapshots runs/wickets/balls on accept and shifts out
// start, runs, wkts, balls (each LSB-first), even parity and stop, one bit per bit period.
module score_frame_tx
    import score_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RUNS_W-1:0]  runs_i,
    input  logic [WKTS_W-1:0]  wkts_i,
    input  logic [BALLS_W-1:0] balls_i,
    input  logic               send_valid,
    output logic               send_ready,
    output logic               tx_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int unsigned BCNT_W = $clog2(DATA_W);
    localparam logic [BCNT_W-1:0] LAST_DATA = BCNT_W'(DATA_W - 1);

    logic [2:0]        r_state;
    // Parity sits above the data so it falls out of the shift right after the last data bit
    logic [DATA_W:0]   r_shift;
    logic [BCNT_W-1:0] r_bit_cnt;
    logic              r_tx;
    logic              r_done;

    logic              w_accept;
    logic              w_busy;
    logic              w_bit_end;
    logic [DATA_W-1:0] w_data;
    logic              w_parity;

    assign w_busy     = (r_state != S_IDLE);
    assign send_ready = ~w_busy;
    assign w_accept   = send_valid & send_ready;
    assign busy_o     = w_busy;
    assign tx_o       = r_tx;
    assign done_o     = r_done;

    // Saturated snapshot word, LSB first on the line: runs, then wkts, then balls
    assign w_data   = {sat_balls(balls_i), sat_wkts(wkts_i), runs_i};
    assign w_parity = ^w_data;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .i_restart(w_accept),
        .i_enable (w_busy),
        .o_bit_end(w_bit_end)
    );

    // Frame sequencer: drives the line a bit at a time and tracks data-bit position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state   <= S_START;
                        r_shift   <= {w_parity, w_data};
                        r_bit_cnt <= '0;
                        r_tx      <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        // After the last data bit the shift LSB is the parity bit
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        if (r_bit_cnt == LAST_DATA) begin
                            r_state   <= S_PARITY;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_frame_tx.sv
// Self-checking bench for score_frame_tx: frame-level reference model plus directed vectors.
module tb_score_frame_tx;

    localparam int CPB       = 16;
    localparam int NBITS     = 22;
    localparam int FRAME_CYC = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] runs_i = '0;
    logic [3:0] wkts_i = '0;
    logic [6:0] balls_i = '0;
    logic       send_valid = 1'b0;
    logic       send_ready;
    logic       tx_o;
    logic       busy_o;
    logic       done_o;

    int n_checks = 0;
    int n_fail   = 0;

    score_frame_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .runs_i    (runs_i),
        .wkts_i    (wkts_i),
        .balls_i   (balls_i),
        .send_valid(send_valid),
        .send_ready(send_ready),
        .tx_o      (tx_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as a bit vector indexed by transmission order
    function automatic logic [21:0] build_frame(input logic [7:0] r, input logic [3:0] w,
                                                input logic [6:0] b);
        int          ws;
        int          bs;
        int          ones;
        logic [21:0] f;
        ws = (int'(w) > 10) ? 10 : int'(w);
        bs = (int'(b) > 120) ? 120 : int'(b);
        f = '0;
        for (int i = 0; i < 8; i++) f[1 + i] = r[i];
        for (int i = 0; i < 4; i++) f[9 + i] = ws[i];
        for (int i = 0; i < 7; i++) f[13 + i] = bs[i];
        ones = 0;
        for (int i = 1; i <= 19; i++) ones += int'(f[i]);
        f[20] = ((ones % 2) == 1);
        f[21] = 1'b1;
        return f;
    endfunction

    // Reference model: an accepted frame occupies FRAME_CYC cycles, then a one-cycle done
    logic        m_active = 1'b0;
    int          m_k      = 0;
    logic        m_done   = 1'b0;
    logic [21:0] m_frame  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_done   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                if (m_k == FRAME_CYC - 1) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end else begin
                    m_k <= m_k + 1;
                end
            end else if (send_valid) begin
                m_active <= 1'b1;
                m_k      <= 0;
                m_frame  <= build_frame(runs_i, wkts_i, balls_i);
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic exp_tx;
        exp_tx = m_active ? m_frame[m_k / CPB] : 1'b1;
        check("tx_o", 32'(tx_o), 32'(exp_tx));
        check("busy_o", 32'(busy_o), 32'(m_active));
        check("send_ready", 32'(send_ready), 32'(!m_active));
        check("done_o", 32'(done_o), 32'(m_done));
    end

    // Start at k=0 (just after the accept edge); sample each bit mid-period, then check done
    task automatic capture(output logic [21:0] f);
        f = '0;
        repeat (8) @(posedge clk);
        #1 f[0] = tx_o;
        for (int b = 1; b < NBITS; b++) begin
            repeat (16) @(posedge clk);
            #1 f[b] = tx_o;
        end
        repeat (8) @(posedge clk);
        #1 check("done_at_352", 32'(done_o), 32'd1);
    endtask

    // Present a snapshot and return just after the accept edge
    task automatic accept(input logic [7:0] r, input logic [3:0] w, input logic [6:0] b);
        @(negedge clk);
        runs_i     = r;
        wkts_i     = w;
        balls_i    = b;
        send_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [21:0] f;
        logic [21:0] f2;
        int          dones;

        // Model pins against hand-computed frames
        check("model_nominal", 32'(build_frame(8'hA5, 4'd3, 7'd45)),
              32'({1'b1, 1'b0, 7'd45, 4'd3, 8'hA5, 1'b0}));
        check("model_sat", 32'(build_frame(8'h07, 4'd15, 7'd127)),
              32'({1'b1, 1'b1, 7'd120, 4'd10, 8'h07, 1'b0}));
        check("model_par1", 32'(build_frame(8'h3C, 4'd2, 7'd5)),
              32'({1'b1, 1'b1, 7'd5, 4'd2, 8'h3C, 1'b0}));

        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_tx", 32'(tx_o), 32'd1);
        check("idle_ready", 32'(send_ready), 32'd1);
        check("idle_busy", 32'(busy_o), 32'd0);
        repeat (100) @(negedge clk);

        // Nominal frame
        accept(8'hA5, 4'd3, 7'd45);
        send_valid = 1'b0;
        check("start_low", 32'(tx_o), 32'd0);
        capture(f);
        check("frame_nominal", 32'(f), 32'({1'b1, 1'b0, 7'd45, 4'd3, 8'hA5, 1'b0}));
        repeat (5) @(negedge clk);

        // Saturation
        accept(8'h07, 4'd15, 7'd127);
        send_valid = 1'b0;
        capture(f);
        check("frame_sat", 32'(f), 32'({1'b1, 1'b1, 7'd120, 4'd10, 8'h07, 1'b0}));
        repeat (5) @(negedge clk);

        // Back-to-back with valid held high
        accept(8'h00, 4'd0, 7'd0);
        capture(f);
        check("frame_b2b_1", 32'(f), 32'h200000);
        check("gap_ready", 32'(send_ready), 32'd1);
        check("gap_tx", 32'(tx_o), 32'd1);
        runs_i  = 8'hFF;
        balls_i = 7'd1;
        @(posedge clk);
        #1;
        check("b2b_start", 32'(tx_o), 32'd0);
        check("b2b_busy", 32'(busy_o), 32'd1);
        send_valid = 1'b0;
        fork
            capture(f2);
            begin
                for (int i = 0; i < 10; i++) begin
                    repeat (15) @(negedge clk);
                    runs_i     = 8'h11;
                    send_valid = 1'b1;
                    @(negedge clk);
                    send_valid = 1'b0;
                end
            end
        join
        check("frame_b2b_2", 32'(f2), 32'({1'b1, 1'b1, 7'd1, 4'd0, 8'hFF, 1'b0}));
        repeat (5) @(negedge clk);

        // Mid-frame asynchronous reset during bit 9
        accept(8'h3C, 4'd2, 7'd5);
        send_valid = 1'b0;
        repeat (9 * 16 + 5) @(posedge clk);
        #2;
        check("bit9_low", 32'(tx_o), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_tx", 32'(tx_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ready", 32'(send_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        check("no_done_after_rst", 32'(dones), 32'd0);
        accept(8'hA5, 4'd3, 7'd45);
        send_valid = 1'b0;
        capture(f);
        check("frame_after_rst", 32'(f), 32'({1'b1, 1'b0, 7'd45, 4'd3, 8'hA5, 1'b0}));
        repeat (5) @(negedge clk);

        // Inputs scrambled every cycle after accept
        accept(8'h5A, 4'd7, 7'd100);
        send_valid = 1'b0;
        fork
            capture(f);
            begin
                for (int i = 0; i < 340; i++) begin
                    @(negedge clk);
                    runs_i  = 8'($urandom);
                    wkts_i  = 4'($urandom);
                    balls_i = 7'($urandom);
                end
            end
        join
        check("frame_stable", 32'(f), 32'({1'b1, 1'b0, 7'd100, 4'd7, 8'h5A, 1'b0}));
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
